sequence_detector: RTL and testbench

//   Serial bit-stream pattern detector with a runtime-programmable k-bit pattern.
//   One bit is sampled from `in` every clock; `out` pulses when the last k bits

---
 rtl/sequence_detector.sv | 73 +++++++
 tb/tb_sequence_detector.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sequence_detector.sv
// Serial pattern detector: flags when the last k sampled bits equal a programmable pattern.
// Registered output (match visible the cycle after the final bit); pattern load via valid/ready, never backpressures once out of reset.
module sequence_detector #(
  parameter int k = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [k-1:0] pattern_in,
  input  logic         pattern_valid,
  output logic         pattern_ready,
  input  logic         in,
  output logic         out
);

  localparam int HW = (k > 1) ? k - 1 : 1;
  localparam int CW = $clog2(k + 1);

  logic [k-1:0]  pat_q, pat_d;
  logic [HW-1:0] hist_q, hist_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rdy_q;
  logic [k-1:0]  win;
  logic          load;

  // Window of the k most recent bits, current sample in the LSB.
  generate
    if (k > 1) begin : g_win
      assign win = {hist_q[k-2:0], in};
    end else begin : g_win1
      assign win = in;
    end
  endgenerate

  assign load = pattern_valid && rdy_q;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    cnt_d  = cnt_q;
    out_d  = 1'b0;
    if (load) begin
      // The load-cycle bit is the first bit of the new history.
      pat_d  = pattern_in;
      hist_d = (k > 1) ? HW'(in) : '0;
      cnt_d  = CW'(1);
    end else begin
      out_d  = ((int'(cnt_q) + 1) >= k) && (win == pat_q);
      hist_d = (k > 1) ? win[HW-1:0] : '0;
      if (int'(cnt_q) < k) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pat_q  <= '1;
      hist_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rdy_q  <= 1'b1;
    end
  end

  assign pattern_ready = rdy_q;
  assign out           = out_q;

endmodule

// File: tb/tb_sequence_detector.sv
// Directed checks of sequence_detector (k=3) plus a random stream against a bit-queue reference.
module tb_sequence_detector;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] pattern_in;
  logic       pattern_valid;
  logic       pattern_ready;
  logic       in;
  logic       out;

  int total = 0;
  int bad   = 0;

  sequence_detector #(.k(3)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pattern_in   (pattern_in),
    .pattern_valid(pattern_valid),
    .pattern_ready(pattern_ready),
    .in           (in),
    .out          (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, return just after it.
  task automatic cyc(input logic r, input logic vin, input logic pv, input logic [2:0] pt);
    rstn          = r;
    in            = vin;
    pattern_valid = pv;
    pattern_in    = pt;
    @(posedge clk);
    #1;
  endtask

  // Reference state for the random phase.
  logic [2:0] m_pat;
  bit         m_rdy;
  bit         q[$];
  logic       m_out;

  initial begin
    rstn = 1'b0; in = 1'b0; pattern_valid = 1'b0; pattern_in = 3'b000;

    // 1: reset, default pattern 111 on stream 1111
    cyc(0, 1, 1, 3'b000);
    chk("rst_out", out, 1'b0);
    chk("rst_rdy", pattern_ready, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t1_b1", out, 1'b0); chk("t1_rdy", pattern_ready, 1'b1);
    cyc(1, 1, 0, 3'b000); chk("t1_b2", out, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t1_b3", out, 1'b1);
    cyc(1, 1, 0, 3'b000); chk("t1_b4", out, 1'b1);

    // 2: load 101 (load-edge bit 0), then 1,0,1,0,1 -> overlapping pulses
    cyc(1, 0, 1, 3'b101); chk("t2_load", out, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t2_b1", out, 1'b0);
    cyc(1, 0, 0, 3'b000); chk("t2_b2", out, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t2_b3", out, 1'b1);
    cyc(1, 0, 0, 3'b000); chk("t2_b4", out, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t2_b5", out, 1'b1);

    // 3: stream ...1,0 then load 010 with bit 1; fill must gate the pre-load 0
    cyc(1, 1, 0, 3'b000); chk("t3_pre1", out, 1'b0);
    cyc(1, 0, 0, 3'b000); chk("t3_pre2", out, 1'b0);
    cyc(1, 1, 1, 3'b010); chk("t3_load", out, 1'b0);
    cyc(1, 0, 0, 3'b000); chk("t3_fill", out, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t3_b3", out, 1'b0);
    cyc(1, 0, 0, 3'b000); chk("t3_match", out, 1'b1);

    // 4: back-to-back loads on an all-zero stream never match
    cyc(1, 0, 1, 3'b000); chk("t4_l0", out, 1'b0);
    cyc(1, 0, 1, 3'b001); chk("t4_l1", out, 1'b0);
    cyc(1, 0, 1, 3'b000); chk("t4_l2", out, 1'b0);
    cyc(1, 0, 1, 3'b000); chk("t4_l3", out, 1'b0);
    cyc(1, 0, 1, 3'b000); chk("t4_l4", out, 1'b0);
    cyc(1, 0, 0, 3'b000); chk("t4_fill", out, 1'b0);
    cyc(1, 0, 0, 3'b000); chk("t4_match", out, 1'b1);

    // 5: reset after 1,0 of pattern 101; load attempt while not ready is dropped
    cyc(1, 1, 1, 3'b101); chk("t5_load", out, 1'b0);
    cyc(1, 0, 0, 3'b000); chk("t5_b2", out, 1'b0);
    cyc(0, 1, 1, 3'b000); chk("t5_rst_out", out, 1'b0); chk("t5_rst_rdy", pattern_ready, 1'b0);
    cyc(1, 1, 1, 3'b101); chk("t5_nrdy", out, 1'b0); chk("t5_rdy", pattern_ready, 1'b1);
    cyc(1, 0, 0, 3'b000); chk("t5_b2b", out, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t5_no101", out, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t5_b4", out, 1'b0);
    cyc(1, 1, 0, 3'b000); chk("t5_111", out, 1'b1);

    // 6: random stream and handshake traffic against a reference window
    m_pat = 3'($urandom_range(0, 7));
    cyc(1, 1'($urandom_range(0, 1)), 1, m_pat);
    chk("t6_load", out, 1'b0);
    q.delete();
    q.push_back(in);
    m_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic       vin, pv;
      logic [2:0] pt;
      vin = 1'($urandom_range(0, 1));
      pv  = ($urandom_range(0, 9) < 2);
      pt  = 3'($urandom_range(0, 7));
      cyc(1, vin, pv, pt);
      if (pv && m_rdy) begin
        m_pat = pt;
        q.delete();
        q.push_back(vin);
        m_out = 1'b0;
      end else begin
        q.push_back(vin);
        if (q.size() > 3) void'(q.pop_front());
        m_out = (q.size() == 3) && ({q[0], q[1], q[2]} == m_pat);
      end
      m_rdy = 1'b1;
      chk("t6_out", out, m_out);
      chk("t6_rdy", pattern_ready, m_rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
